// File: rtl/chunk_sequencer_if.sv
// Chunk sequencer bus: upstream chunk stream, processor input/output pair, downstream stream.
// The master modport is the sequencer's view; the slave modport is the surrounding logic's view.
interface chunk_sequencer_if #(
  parameter int CHUNK_SIZE = 64
);
  localparam int IN_W  = CHUNK_SIZE * 96;
  localparam int OUT_W = CHUNK_SIZE * 216;

  logic [IN_W-1:0]  s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;

  logic [IN_W-1:0]  proc_last_tdata;
  logic [IN_W-1:0]  proc_current_tdata;
  logic             proc_in_tvalid;
  logic             proc_in_tready;
  logic [OUT_W-1:0] proc_out_current_tdata;
  logic [OUT_W-1:0] proc_out_next_tdata;
  logic             proc_out_tready;

  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  modport master (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready,
    output proc_last_tdata, proc_current_tdata, proc_in_tvalid, proc_out_tready,
    input  proc_in_tready, proc_out_current_tdata, proc_out_next_tdata,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready,
    input  proc_last_tdata, proc_current_tdata, proc_in_tvalid, proc_out_tready,
    output proc_in_tready, proc_out_current_tdata, proc_out_next_tdata,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/chunk_sequencer.sv
// Pairs each input chunk with its row predecessor, runs the processor, emits outputs in row order.
// Optional CHUNK_SEQ_STATS_EN adds stat_rows / stat_chunks counters.
//
// state     | meaning
// IDLE      | ready for the next input chunk
// WAIT      | presenting the pair to the processor, then counting its latency
// EMIT_CUR  | emitting the processor's current output chunk
// EMIT_NEXT | emitting the trailing next chunk that closes the row
module chunk_sequencer #(
  parameter int CHUNK_SIZE     = 64,
  parameter int PROC_LATENCY   = 2,
  parameter int MAX_ROW_CHUNKS = 32
) (
  input  logic clk,
  input  logic reset,
  chunk_sequencer_if.master bus,
  output logic err_overrun
`ifdef CHUNK_SEQ_STATS_EN
  ,
  output logic [31:0] stat_rows,
  output logic [31:0] stat_chunks
`endif
);
  localparam int IN_W  = CHUNK_SIZE * 96;
  localparam int OUT_W = CHUNK_SIZE * 216;
  localparam int CNT_W = $clog2(MAX_ROW_CHUNKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EMIT_CUR,
    ST_EMIT_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  last_reg_q, last_reg_d;
  logic [IN_W-1:0]  cur_reg_q, cur_reg_d;
  logic [OUT_W-1:0] cur_out_q, cur_out_d;
  logic [OUT_W-1:0] next_out_q, next_out_d;
  logic             row_end_q, row_end_d;
  logic             first_of_row_q, first_of_row_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [3:0]       lat_cnt_q, lat_cnt_d;
  logic             proc_hs_q, proc_hs_d;
  logic             err_overrun_q, err_overrun_d;

  logic             s_tready_c;
  logic             proc_in_tvalid_c;
  logic             proc_out_tready_c;
  logic             m_tvalid_c;
  logic             m_tlast_c;
  logic [OUT_W-1:0] m_tdata_c;
  logic             row_full;

  assign row_full = (row_cnt_q == CNT_W'(MAX_ROW_CHUNKS - 1));

  always_comb begin
    state_d           = state_q;
    last_reg_d        = last_reg_q;
    cur_reg_d         = cur_reg_q;
    cur_out_d         = cur_out_q;
    next_out_d        = next_out_q;
    row_end_d         = row_end_q;
    first_of_row_d    = first_of_row_q;
    row_cnt_d         = row_cnt_q;
    lat_cnt_d         = lat_cnt_q;
    proc_hs_d         = proc_hs_q;
    err_overrun_d     = err_overrun_q;
    s_tready_c        = 1'b0;
    proc_in_tvalid_c  = 1'b0;
    proc_out_tready_c = 1'b0;
    m_tvalid_c        = 1'b0;
    m_tlast_c         = 1'b0;
    m_tdata_c         = '0;

    case (state_q)
      ST_IDLE: begin
        s_tready_c = 1'b1;
        if (bus.s_tvalid) begin
          last_reg_d = first_of_row_q ? '0 : cur_reg_q;
          cur_reg_d  = bus.s_tdata;
          row_end_d  = bus.s_tlast | row_full;
          // A row closed only by the chunk limit is an overrun; it still ends normally.
          if (row_full && !bus.s_tlast) begin
            err_overrun_d = 1'b1;
          end
          proc_hs_d = 1'b0;
          lat_cnt_d = 4'd0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        proc_out_tready_c = 1'b1;
        if (!proc_hs_q) begin
          proc_in_tvalid_c = 1'b1;
          if (bus.proc_in_tready) begin
            proc_hs_d = 1'b1;
            lat_cnt_d = 4'd1;
          end
        end else if (lat_cnt_q == 4'(PROC_LATENCY)) begin
          cur_out_d  = bus.proc_out_current_tdata;
          next_out_d = bus.proc_out_next_tdata;
          state_d    = ST_EMIT_CUR;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end

      ST_EMIT_CUR: begin
        m_tvalid_c = 1'b1;
        m_tdata_c  = cur_out_q;
        if (bus.m_tready) begin
          if (row_end_q) begin
            state_d = ST_EMIT_NEXT;
          end else begin
            row_cnt_d      = row_cnt_q + 1'b1;
            first_of_row_d = 1'b0;
            state_d        = ST_IDLE;
          end
        end
      end

      ST_EMIT_NEXT: begin
        m_tvalid_c = 1'b1;
        m_tlast_c  = 1'b1;
        m_tdata_c  = next_out_q;
        if (bus.m_tready) begin
          row_cnt_d      = '0;
          first_of_row_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_reg_q     <= '0;
      cur_reg_q      <= '0;
      cur_out_q      <= '0;
      next_out_q     <= '0;
      row_end_q      <= 1'b0;
      first_of_row_q <= 1'b1;
      row_cnt_q      <= '0;
      lat_cnt_q      <= 4'd0;
      proc_hs_q      <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_reg_q     <= last_reg_d;
      cur_reg_q      <= cur_reg_d;
      cur_out_q      <= cur_out_d;
      next_out_q     <= next_out_d;
      row_end_q      <= row_end_d;
      first_of_row_q <= first_of_row_d;
      row_cnt_q      <= row_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      proc_hs_q      <= proc_hs_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  // Handshake outputs are masked while reset is held so no transfer can complete during it.
  assign bus.s_tready           = s_tready_c & ~reset;
  assign bus.proc_in_tvalid     = proc_in_tvalid_c & ~reset;
  assign bus.proc_out_tready    = proc_out_tready_c & ~reset;
  assign bus.m_tvalid           = m_tvalid_c & ~reset;
  assign bus.m_tlast            = m_tlast_c & ~reset;
  assign bus.m_tdata            = m_tdata_c;
  assign bus.proc_last_tdata    = last_reg_q;
  assign bus.proc_current_tdata = cur_reg_q;
  assign err_overrun            = err_overrun_q;

`ifdef CHUNK_SEQ_STATS_EN
  logic [31:0] stat_rows_q, stat_rows_d;
  logic [31:0] stat_chunks_q, stat_chunks_d;

  always_comb begin
    stat_rows_d   = stat_rows_q;
    stat_chunks_d = stat_chunks_q;
    if (state_q == ST_EMIT_NEXT && bus.m_tready) begin
      stat_rows_d = stat_rows_q + 32'd1;
    end
    if (state_q == ST_IDLE && bus.s_tvalid) begin
      stat_chunks_d = stat_chunks_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rows_q   <= '0;
      stat_chunks_q <= '0;
    end else begin
      stat_rows_q   <= stat_rows_d;
      stat_chunks_q <= stat_chunks_d;
    end
  end

  assign stat_rows   = stat_rows_q;
  assign stat_chunks = stat_chunks_q;
`endif
endmodule

// File: doc/chunk_sequencer.md
# chunk_sequencer

- Drives one `processor_interface` instance from a single upstream chunk stream.
- Pairs each incoming 2×2-block chunk with its predecessor in the same row, presents the pair to the processor, and waits a fixed latency.
- Captures the 3×3 output chunks and emits them downstream in row order, appending the trailing "next" chunk at each row end.
- Sits between the input chunk FIFO and the output packer.

## Interface
- `CHUNK_SIZE`, 64: pixels-blocks per chunk. IN_W = CHUNK_SIZE*96, OUT_W = CHUNK_SIZE*216.
- `PROC_LATENCY`, 2: cycles from processor-input handshake to valid processor outputs (1..15).
- `MAX_ROW_CHUNKS`, 32: maximum input chunks per row (≥2).

Ports:
- `clk` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `s_tdata` in IN_W: input chunk.
- `s_tvalid` in 1: input valid.
- `s_tready` out 1: input ready.
- `s_tlast` in 1: chunk is last of its row.
- `proc_last_tdata` out IN_W: previous chunk, or zero at the start of a row.
- `proc_current_tdata` out IN_W: current chunk.
- `proc_in_tvalid` out 1: processor input valid; drives both input tvalids.
- `proc_in_tready` in 1: AND of the processor's input treadys.
- `proc_out_current_tdata` in OUT_W: processor current output.
- `proc_out_next_tdata` in OUT_W: processor next output.
- `proc_out_tready` out 1: drives both processor output treadys.
- `m_tdata` out OUT_W: output chunk.
- `m_tvalid` out 1: output valid.
- `m_tready` in 1: downstream ready.
- `m_tlast` out 1: last output chunk of the row.
- `err_overrun` out 1: sticky; row exceeded MAX_ROW_CHUNKS.

## Operation
- **State machine:** IDLE → WAIT → EMIT_CUR → (EMIT_NEXT) → IDLE.
- **IDLE**
  - `s_tready`=1.
  - On `s_tvalid`: `last_reg` ← (`first_of_row` ? 0 : `cur_reg`); `cur_reg` ← `s_tdata`; `row_end` ← `s_tlast` OR (`row_cnt` == MAX_ROW_CHUNKS-1). Go to WAIT.
- **WAIT**
  - `proc_in_tvalid`=1 until a `proc_in_tready` handshake.
  - A 4-bit latency counter then counts up; `proc_out_tready`=1 throughout WAIT.
  - On the PROC_LATENCY-th cycle after the handshake: `cur_out` ← `proc_out_current_tdata`, `next_out` ← `proc_out_next_tdata`. Go to EMIT_CUR.
- **EMIT_CUR**
  - `m_tdata`=`cur_out`, `m_tvalid`=1, `m_tlast`=0.
  - On `m_tready`: if `row_end`, go to EMIT_NEXT; else `row_cnt`++, `first_of_row` ← 0, go to IDLE.
- **EMIT_NEXT**
  - `m_tdata`=`next_out`, `m_tvalid`=1, `m_tlast`=1.
  - On `m_tready`: `row_cnt` ← 0, `first_of_row` ← 1, go to IDLE.
- **Row output:** a row of N input chunks yields N+1 output chunks.
- **Overrun:** a forced row end with `s_tlast`=0 sets `err_overrun`, which holds until reset. The row is closed normally. The next chunk starts a new row.
- **Processor inputs:** `proc_last_tdata`/`proc_current_tdata` are driven from `last_reg`/`cur_reg` continuously and are stable from handshake to capture.

## Timing
- **Reset values:** `s_tready`, `proc_in_tvalid`, `proc_out_tready`, `m_tvalid`, `m_tlast`, `err_overrun` are 0. All data registers are 0. `first_of_row`=1, `row_cnt`=0, state=IDLE.
- `s_tready` is 1 from the first cycle after reset deasserts.
- **Latency with all readys high:** input handshake at T → `proc_in` handshake at T+1 → capture at T+1+PROC_LATENCY → `m_tvalid` at T+2+PROC_LATENCY.
- **Throughput:** one input chunk per PROC_LATENCY+3 cycles in mid-row; one extra cycle per row end.
- **Backpressure:** while `m_tvalid`=1 and `m_tready`=0, `m_tdata`/`m_tlast` hold stable and `s_tready`=0.
- **Processor stall:** if `proc_in_tready`=0, the state remains WAIT with `proc_in_tvalid`=1; the counter does not start.
- **Reset mid-operation:** in-flight chunks are discarded. No output beat completes after the reset cycle.
- **Simultaneous events:** an `m_tready` handshake and a new `s_tvalid` in the same cycle do not overlap. The input is accepted in the following IDLE cycle.

## Configuration
- **`CHUNK_SEQ_STATS_EN` defined:** adds 32-bit outputs `stat_rows` and `stat_chunks`.
  - `stat_rows` increments on each EMIT_NEXT handshake.
  - `stat_chunks` increments on each input handshake.
  - Both reset to 0 and wrap at 2^32.
- **`CHUNK_SEQ_STATS_EN` undefined:** these ports and counters do not exist; all other behaviour is identical.

## Test plan
All scenarios use CHUNK_SIZE=1 and PROC_LATENCY=2.
- **Single chunk:** one row of 1 chunk `0xA..A`, `s_tlast`=1, processor returns cur `0x11..`, next `0x22..`
  - → two output beats `0x11..` (`m_tlast`=0) then `0x22..` (`m_tlast`=1).
  - → `proc_last_tdata`=0 throughout.
- **Pairing:** row of 3 chunks C0, C1, C2
  - → processor sees pairs (0,C0), (C0,C1), (C1,C2).
  - → 4 output beats; `m_tlast` only on the 4th.
- **Latency:** all readys 1, input handshake at cycle 10 → `m_tvalid` first high at cycle 14.
- **Output backpressure:** `m_tready`=0 for 5 cycles during EMIT_CUR → `m_tdata` constant, `s_tready`=0; the beat completes the cycle `m_tready` returns to 1.
- **Overrun:** MAX_ROW_CHUNKS=4, 5 chunks with no `s_tlast`
  - → the 4th chunk is followed by an `m_tlast` beat.
  - → `err_overrun`=1 and stays 1.
  - → the 5th chunk pairs with zero.
- **Reset mid-row:** reset during WAIT → next cycle all outputs at reset values; the next chunk pairs with zero.
